// File: rtl/i2c_link_pkg.sv
// ---------------------------------------------------------------------------
// i2c_link_pkg
// Shared types and constants for the board-to-board ball handoff link:
//   handoff_state_e : sequencing states of ball_handoff_ctrl
//   HDR_NIBBLE      : required upper nibble of frame byte 0
//   Y_MAX           : largest legal spawn row
//   ball_frame_t    : decoded frame fields
//   sat_inc8        : saturating 8-bit increment used by the event counters
// ---------------------------------------------------------------------------
package i2c_link_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CAPTURE = 3'd1,
      ST_CHECK   = 3'd2,
      ST_LAUNCH  = 3'd3,
      ST_ACK     = 3'd4
   } handoff_state_e;

   localparam logic [3:0] HDR_NIBBLE = 4'hA;
   localparam logic [8:0] Y_MAX      = 9'd479;

   typedef struct packed {
      logic [3:0] seq;
      logic [8:0] y;
      logic       dir_up;
      logic [2:0] speed_y;
      logic [2:0] speed_x;
      logic [7:0] score;
   } ball_frame_t;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/i2c_frame_check.sv
// ---------------------------------------------------------------------------
// i2c_frame_check
// Purely combinational decode and validation of one captured handoff frame.
//   i_b0..i_b4 : shadow copy of the five received bytes
//   o_good     : header, checksum and row range are all valid
//   o_frame    : decoded fields (meaningful only when o_good=1)
// ---------------------------------------------------------------------------
module i2c_frame_check
   import i2c_link_pkg::*;
(
   input  logic [7:0]  i_b0,
   input  logic [7:0]  i_b1,
   input  logic [7:0]  i_b2,
   input  logic [7:0]  i_b3,
   input  logic [7:0]  i_b4,
   output logic        o_good,
   output ball_frame_t o_frame
);

   logic w_hdr_ok;
   logic w_csum_ok;
   logic w_y_ok;

   assign o_frame.seq     = i_b0[3:0];
   assign o_frame.y       = {i_b2[7], i_b1};
   assign o_frame.dir_up  = i_b2[6];
   assign o_frame.speed_y = i_b2[5:3];
   assign o_frame.speed_x = i_b2[2:0];
   assign o_frame.score   = i_b3;

   assign w_hdr_ok  = (i_b0[7:4] == HDR_NIBBLE);
   assign w_csum_ok = ((i_b0 ^ i_b1 ^ i_b2 ^ i_b3) == i_b4);
   assign w_y_ok    = (o_frame.y <= Y_MAX);

   assign o_good = w_hdr_ok && w_csum_ok && w_y_ok;

endmodule

// File: rtl/ball_handoff_ctrl.sv
// ---------------------------------------------------------------------------
// ball_handoff_ctrl
// Consumes ball-handoff frames from the I2C slave: snapshots the five slave
// registers, validates them, offers the decoded ball over valid/ready, then
// acknowledges the slave until it drops go_left (or the ack times out).
// Ports:
//   clk, reset (async, active-low)
//   slv_reg0..4        : received frame bytes, stable while go_left=1
//   go_left            : slave has a complete frame and waits for ack
//   responsing_i2c_pl  : acknowledge to the slave (registered)
//   ball_valid/ready   : handshake towards the game logic
//   ball_y, ball_dir_up, ball_speed_x, ball_speed_y, remote_score :
//                        last accepted ball parameters (registered)
//   err_count, dup_count : saturating rejected / duplicate frame counters
// ---------------------------------------------------------------------------
module ball_handoff_ctrl
   import i2c_link_pkg::*;
#(
   parameter int unsigned ACK_TIMEOUT = 1_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] slv_reg0,
   input  logic [7:0] slv_reg1,
   input  logic [7:0] slv_reg2,
   input  logic [7:0] slv_reg3,
   input  logic [7:0] slv_reg4,
   input  logic       go_left,
   output logic       responsing_i2c_pl,
   output logic       ball_valid,
   input  logic       ball_ready,
   output logic [8:0] ball_y,
   output logic       ball_dir_up,
   output logic [2:0] ball_speed_x,
   output logic [2:0] ball_speed_y,
   output logic [7:0] remote_score,
   output logic [7:0] err_count,
   output logic [7:0] dup_count
);

   localparam int unsigned CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

   handoff_state_e r_state;
   handoff_state_e w_next;

   logic [7:0]       r_sh0, r_sh1, r_sh2, r_sh3, r_sh4;
   logic             w_good;
   ball_frame_t      w_frame;
   logic             w_is_dup;
   logic             r_seq_seen;
   logic [3:0]       r_last_seq;
   logic [CNT_W-1:0] r_ack_cnt;
   logic             w_load;
   logic             w_err_inc;
   logic             w_dup_inc;

   logic             r_ball_valid;
   logic             r_ack;
   ball_frame_t      r_ball;
   logic [7:0]       r_err_cnt;
   logic [7:0]       r_dup_cnt;

   i2c_frame_check u_check (
      .i_b0    (r_sh0),
      .i_b1    (r_sh1),
      .i_b2    (r_sh2),
      .i_b3    (r_sh3),
      .i_b4    (r_sh4),
      .o_good  (w_good),
      .o_frame (w_frame)
   );

   assign w_is_dup = r_seq_seen && (w_frame.seq == r_last_seq);

   // Shadow copy: the slave may change its registers once go_left drops,
   // so decoding never looks at slv_reg* directly.
   always_ff @(posedge clk) begin
      if (r_state == ST_CAPTURE) begin
         r_sh0 <= slv_reg0;
         r_sh1 <= slv_reg1;
         r_sh2 <= slv_reg2;
         r_sh3 <= slv_reg3;
         r_sh4 <= slv_reg4;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      w_load    = 1'b0;
      w_err_inc = 1'b0;
      w_dup_inc = 1'b0;
      case (r_state)
         ST_IDLE:    if (go_left) w_next = ST_CAPTURE;
         ST_CAPTURE: w_next = ST_CHECK;
         ST_CHECK: begin
            if (!w_good) begin
               w_err_inc = 1'b1;
               w_next    = ST_ACK;
            end else if (w_is_dup) begin
               w_dup_inc = 1'b1;
               w_next    = ST_ACK;
            end else begin
               w_load = 1'b1;
               w_next = ST_LAUNCH;
            end
         end
         ST_LAUNCH:  if (r_ball_valid && ball_ready) w_next = ST_ACK;
         ST_ACK: begin
            // A released go_left wins over a timeout landing on the same cycle.
            if (!go_left) begin
               w_next = ST_IDLE;
            end else if (r_ack_cnt == CNT_LAST) begin
               w_err_inc = 1'b1;
               w_next    = ST_IDLE;
            end
         end
         default:    w_next = ST_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with the
   // state they describe without any input-to-output combinational path.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ack_cnt    <= '0;
         r_seq_seen   <= 1'b0;
         r_last_seq   <= '0;
         r_ball_valid <= 1'b0;
         r_ack        <= 1'b0;
         r_ball       <= '0;
         r_err_cnt    <= '0;
         r_dup_cnt    <= '0;
      end else begin
         r_ack_cnt    <= (r_state == ST_ACK) ? r_ack_cnt + CNT_W'(1) : '0;
         r_ball_valid <= (w_next == ST_LAUNCH);
         r_ack        <= (w_next == ST_ACK);
         if (w_load) begin
            r_ball     <= w_frame;
            r_last_seq <= w_frame.seq;
            r_seq_seen <= 1'b1;
         end
         if (w_err_inc) r_err_cnt <= sat_inc8(r_err_cnt);
         if (w_dup_inc) r_dup_cnt <= sat_inc8(r_dup_cnt);
      end
   end

   assign responsing_i2c_pl = r_ack;
   assign ball_valid        = r_ball_valid;
   assign ball_y            = r_ball.y;
   assign ball_dir_up       = r_ball.dir_up;
   assign ball_speed_x      = r_ball.speed_x;
   assign ball_speed_y      = r_ball.speed_y;
   assign remote_score      = r_ball.score;
   assign err_count         = r_err_cnt;
   assign dup_count         = r_dup_cnt;

endmodule

// File: tb/tb_ball_handoff_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ball_handoff_ctrl
// Scenario tasks driving ball_handoff_ctrl with ACK_TIMEOUT=16. Expected
// values come from a frame-level model (frame classification, last accepted
// ball, counters) built from the frame format rules.
// ---------------------------------------------------------------------------
module tb_ball_handoff_ctrl;

   localparam int TO = 16;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] slv_reg0, slv_reg1, slv_reg2, slv_reg3, slv_reg4;
   logic       go_left;
   logic       responsing_i2c_pl;
   logic       ball_valid;
   logic       ball_ready;
   logic [8:0] ball_y;
   logic       ball_dir_up;
   logic [2:0] ball_speed_x;
   logic [2:0] ball_speed_y;
   logic [7:0] remote_score;
   logic [7:0] err_count;
   logic [7:0] dup_count;

   ball_handoff_ctrl #(.ACK_TIMEOUT(TO)) dut (
      .clk               (clk),
      .reset             (reset),
      .slv_reg0          (slv_reg0),
      .slv_reg1          (slv_reg1),
      .slv_reg2          (slv_reg2),
      .slv_reg3          (slv_reg3),
      .slv_reg4          (slv_reg4),
      .go_left           (go_left),
      .responsing_i2c_pl (responsing_i2c_pl),
      .ball_valid        (ball_valid),
      .ball_ready        (ball_ready),
      .ball_y            (ball_y),
      .ball_dir_up       (ball_dir_up),
      .ball_speed_x      (ball_speed_x),
      .ball_speed_y      (ball_speed_y),
      .remote_score      (remote_score),
      .err_count         (err_count),
      .dup_count         (dup_count)
   );

   always #5 clk = ~clk;

   wire [23:0] dut_ball = {ball_y, ball_dir_up, ball_speed_y, ball_speed_x, remote_score};

   int n_checks = 0;
   int n_fail   = 0;

   // Frame-level reference state
   int          m_err;
   int          m_dup;
   bit          m_seen;
   int          m_last;
   logic [23:0] m_ball;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int sat(input int v);
      return (v >= 255) ? 255 : v + 1;
   endfunction

   // 0 = rejected, 1 = duplicate, 2 = good and new
   function automatic int kind_of(input logic [7:0] b0, b1, b2, b3, b4);
      int y;
      bit ok;
      y  = (int'(b2) / 128) * 256 + int'(b1);
      ok = (int'(b0) / 16 == 10) && ((b0 ^ b1 ^ b2 ^ b3) == b4) && (y < 480);
      if (!ok) return 0;
      if (m_seen && (int'(b0) % 16 == m_last)) return 1;
      return 2;
   endfunction

   function automatic logic [23:0] expect_ball(input logic [7:0] b1, b2, b3);
      int y, dir, sy, sx;
      y   = (int'(b2) / 128) * 256 + int'(b1);
      dir = (int'(b2) / 64) % 2;
      sy  = (int'(b2) / 8) % 8;
      sx  = int'(b2) % 8;
      return {9'(y), 1'(dir), 3'(sy), 3'(sx), b3};
   endfunction

   task automatic build(input int seq, y, dir, sy, sx, sc,
                        output logic [7:0] b0, b1, b2, b3, b4);
      b0 = 8'(160 + seq);
      b1 = 8'(y % 256);
      b2 = 8'((y / 256) * 128 + dir * 64 + sy * 8 + sx);
      b3 = 8'(sc);
      b4 = b0 ^ b1 ^ b2 ^ b3;
   endtask

   task automatic model_reset();
      m_err  = 0;
      m_dup  = 0;
      m_seen = 0;
      m_last = 0;
      m_ball = '0;
   endtask

   // One complete transaction with checks at every protocol milestone.
   task automatic run_frame(input logic [7:0] b0, b1, b2, b3, b4,
                            input int rdy_wait, input int ack_hold, input bit early_drop);
      int          k;
      logic [23:0] prev_ball;
      k         = kind_of(b0, b1, b2, b3, b4);
      prev_ball = m_ball;
      case (k)
         0:       m_err = sat(m_err);
         1:       m_dup = sat(m_dup);
         default: begin
            m_ball = expect_ball(b1, b2, b3);
            m_seen = 1;
            m_last = int'(b0) % 16;
         end
      endcase
      slv_reg0 = b0; slv_reg1 = b1; slv_reg2 = b2; slv_reg3 = b3; slv_reg4 = b4;
      go_left    = 1'b1;
      ball_ready = (rdy_wait == 0);
      step();  // cycle 1
      step();  // cycle 2
      n_checks++;
      if ({ball_valid, responsing_i2c_pl} !== 2'b00) begin
         n_fail++; $display("FAIL cycle2_idle valid/ack got=%b exp=00", {ball_valid, responsing_i2c_pl});
      end
      if (early_drop) begin
         go_left  = 1'b0;
         slv_reg0 = 8'($urandom); slv_reg1 = 8'($urandom); slv_reg2 = 8'($urandom);
         slv_reg3 = 8'($urandom); slv_reg4 = 8'($urandom);
      end
      step();  // cycle 3
      if (k == 2) begin
         n_checks++;
         if ({ball_valid, responsing_i2c_pl} !== 2'b10) begin
            n_fail++; $display("FAIL launch_cycle3 valid/ack got=%b exp=10", {ball_valid, responsing_i2c_pl});
         end
         n_checks++;
         if (dut_ball !== m_ball) begin
            n_fail++; $display("FAIL launch_data got=%h exp=%h", dut_ball, m_ball);
         end
         for (int i = 0; i < rdy_wait; i++) begin
            step();
            n_checks++;
            if ({ball_valid, responsing_i2c_pl, dut_ball} !== {2'b10, m_ball}) begin
               n_fail++; $display("FAIL backpressure_hold got=%b_%h exp=10_%h",
                                  {ball_valid, responsing_i2c_pl}, dut_ball, m_ball);
            end
         end
         ball_ready = 1'b1;
         step();
         ball_ready = 1'b0;
         n_checks++;
         if ({ball_valid, responsing_i2c_pl} !== 2'b01) begin
            n_fail++; $display("FAIL ack_after_accept valid/ack got=%b exp=01", {ball_valid, responsing_i2c_pl});
         end
      end else begin
         n_checks++;
         if ({ball_valid, responsing_i2c_pl} !== 2'b01) begin
            n_fail++; $display("FAIL reject_ack_cycle3 valid/ack got=%b exp=01", {ball_valid, responsing_i2c_pl});
         end
         n_checks++;
         if ({err_count, dup_count} !== {8'(m_err), 8'(m_dup)}) begin
            n_fail++; $display("FAIL reject_counts err/dup got=%0d/%0d exp=%0d/%0d", err_count, dup_count, m_err, m_dup);
         end
         n_checks++;
         if (dut_ball !== prev_ball) begin
            n_fail++; $display("FAIL reject_ball_hold got=%h exp=%h", dut_ball, prev_ball);
         end
      end
      if (early_drop) begin
         step();
      end else begin
         for (int i = 0; i < ack_hold; i++) begin
            step();
            n_checks++;
            if (responsing_i2c_pl !== 1'b1) begin
               n_fail++; $display("FAIL ack_hold got=%b exp=1", responsing_i2c_pl);
            end
         end
         go_left = 1'b0;
         step();
      end
      n_checks++;
      if ({ball_valid, responsing_i2c_pl} !== 2'b00) begin
         n_fail++; $display("FAIL ack_release valid/ack got=%b exp=00", {ball_valid, responsing_i2c_pl});
      end
      n_checks++;
      if ({err_count, dup_count, dut_ball} !== {8'(m_err), 8'(m_dup), m_ball}) begin
         n_fail++; $display("FAIL frame_end err/dup/ball got=%0d/%0d/%h exp=%0d/%0d/%h",
                            err_count, dup_count, dut_ball, m_err, m_dup, m_ball);
      end
      step();
   endtask

   task automatic test_reset();
      reset = 1'b0; go_left = 1'b0; ball_ready = 1'b0;
      slv_reg0 = '0; slv_reg1 = '0; slv_reg2 = '0; slv_reg3 = '0; slv_reg4 = '0;
      model_reset();
      #12;
      n_checks++;
      if ({ball_valid, responsing_i2c_pl, dut_ball, err_count, dup_count} !== 42'd0) begin
         n_fail++; $display("FAIL reset_outputs got=%b_%b_%h_%0d_%0d exp=all zero",
                            ball_valid, responsing_i2c_pl, dut_ball, err_count, dup_count);
      end
      step();
      reset = 1'b1;
      step();
   endtask

   task automatic test_good_frame();
      run_frame(8'hA1, 8'h64, 8'h9B, 8'h03, 8'h5D, 0, 3, 1'b0);
      n_checks++;
      if (dut_ball !== {9'd356, 1'b0, 3'd3, 3'd3, 8'd3}) begin
         n_fail++; $display("FAIL good_decode got=%h exp=%h", dut_ball, {9'd356, 1'b0, 3'd3, 3'd3, 8'd3});
      end
   endtask

   task automatic test_bad_checksum();
      run_frame(8'hA1, 8'h64, 8'h9B, 8'h03, 8'h5C, 0, 1, 1'b0);
      n_checks++;
      if (err_count !== 8'd1) begin
         n_fail++; $display("FAIL bad_checksum_err got=%0d exp=1", err_count);
      end
   endtask

   task automatic test_duplicate();
      logic [7:0] b0, b1, b2, b3, b4;
      run_frame(8'hA1, 8'h64, 8'h9B, 8'h03, 8'h5D, 0, 1, 1'b0);
      n_checks++;
      if (dup_count !== 8'd1) begin
         n_fail++; $display("FAIL duplicate_count got=%0d exp=1", dup_count);
      end
      build(2, 123, 1, 4, 5, 77, b0, b1, b2, b3, b4);
      run_frame(b0, b1, b2, b3, b4, 1, 2, 1'b0);
   endtask

   task automatic test_backpressure();
      logic [7:0] b0, b1, b2, b3, b4;
      build(3, 479, 0, 7, 1, 200, b0, b1, b2, b3, b4);
      run_frame(b0, b1, b2, b3, b4, 20, 2, 1'b0);
   endtask

   task automatic test_timeout();
      logic [7:0] b0, b1, b2, b3, b4;
      build(4, 10, 1, 2, 6, 9, b0, b1, b2, b3, b4);
      m_ball = expect_ball(b1, b2, b3); m_seen = 1; m_last = 4;
      slv_reg0 = b0; slv_reg1 = b1; slv_reg2 = b2; slv_reg3 = b3; slv_reg4 = b4;
      go_left = 1'b1; ball_ready = 1'b1;
      step(); step(); step();
      step();
      ball_ready = 1'b0;
      n_checks++;
      if (responsing_i2c_pl !== 1'b1) begin
         n_fail++; $display("FAIL timeout_ack_start got=%b exp=1", responsing_i2c_pl);
      end
      for (int i = 1; i < TO; i++) begin
         step();
         n_checks++;
         if (responsing_i2c_pl !== 1'b1) begin
            n_fail++; $display("FAIL timeout_ack_held cycle=%0d got=%b exp=1", i, responsing_i2c_pl);
         end
      end
      step();
      go_left = 1'b0;
      m_err = sat(m_err);
      n_checks++;
      if ({responsing_i2c_pl, err_count} !== {1'b0, 8'(m_err)}) begin
         n_fail++; $display("FAIL timeout_expire ack/err got=%b/%0d exp=0/%0d", responsing_i2c_pl, err_count, m_err);
      end
      step(); step();
   endtask

   task automatic test_y_range();
      logic [7:0] b0, b1, b2, b3, b4;
      build(5, 480, 0, 1, 1, 1, b0, b1, b2, b3, b4);
      n_checks++;
      if ({b1, b2[7]} !== {8'hE0, 1'b1}) begin
         n_fail++; $display("FAIL y480_encoding got=%h exp=E0/1", {b1, b2[7]});
      end
      run_frame(b0, b1, b2, b3, b4, 0, 0, 1'b0);
      build(5, 511, 1, 1, 1, 1, b0, b1, b2, b3, b4);
      run_frame(b0, b1, b2, b3, b4, 0, 0, 1'b0);
      build(5, 479, 1, 0, 0, 255, b0, b1, b2, b3, b4);
      run_frame(b0, b1, b2, b3, b4, 0, 0, 1'b0);
   endtask

   task automatic test_early_drop();
      logic [7:0] b0, b1, b2, b3, b4;
      build(6, 0, 0, 5, 5, 66, b0, b1, b2, b3, b4);
      run_frame(b0, b1, b2, b3, b4, 2, 0, 1'b1);
      run_frame(8'h36, 8'h00, 8'h00, 8'h00, 8'h36, 0, 0, 1'b1);
   endtask

   task automatic test_reset_mid_launch();
      logic [7:0] b0, b1, b2, b3, b4;
      build(7, 300, 1, 3, 3, 12, b0, b1, b2, b3, b4);
      slv_reg0 = b0; slv_reg1 = b1; slv_reg2 = b2; slv_reg3 = b3; slv_reg4 = b4;
      go_left = 1'b1; ball_ready = 1'b0;
      step(); step(); step(); step();
      n_checks++;
      if (ball_valid !== 1'b1) begin
         n_fail++; $display("FAIL mid_launch_valid got=%b exp=1", ball_valid);
      end
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      n_checks++;
      if ({ball_valid, responsing_i2c_pl, dut_ball, err_count, dup_count} !== 42'd0) begin
         n_fail++; $display("FAIL async_reset_outputs got=%b_%b_%h_%0d_%0d exp=all zero",
                            ball_valid, responsing_i2c_pl, dut_ball, err_count, dup_count);
      end
      go_left = 1'b0;
      step();
      reset = 1'b1;
      step();
      run_frame(8'hA1, 8'h64, 8'h9B, 8'h03, 8'h5D, 0, 1, 1'b0);
      n_checks++;
      if ({dup_count, dut_ball} !== {8'd0, 9'd356, 1'b0, 3'd3, 3'd3, 8'd3}) begin
         n_fail++; $display("FAIL resend_after_reset dup/ball got=%0d/%h", dup_count, dut_ball);
      end
   endtask

   task automatic test_random();
      logic [7:0] b0, b1, b2, b3, b4;
      logic [7:0] lb0, lb1, lb2, lb3, lb4;
      int sel;
      build(9, 50, 0, 1, 2, 3, lb0, lb1, lb2, lb3, lb4);
      for (int n = 0; n < 40; n++) begin
         sel = int'($urandom_range(0, 9));
         build(int'($urandom_range(0, 15)), int'($urandom_range(0, 511)), int'($urandom_range(0, 1)),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
               b0, b1, b2, b3, b4);
         if (sel < 2) begin
            b0 = lb0; b1 = lb1; b2 = lb2; b3 = lb3; b4 = lb4;
         end else if (sel == 2) begin
            b4 = b4 ^ 8'(1 << $urandom_range(0, 7));
         end else if (sel == 3) begin
            b0 = b0 ^ 8'h40;
            b4 = b0 ^ b1 ^ b2 ^ b3;
         end else begin
            lb0 = b0; lb1 = b1; lb2 = b2; lb3 = b3; lb4 = b4;
         end
         run_frame(b0, b1, b2, b3, b4, int'($urandom_range(0, 3)), int'($urandom_range(0, 5)),
                   ($urandom_range(0, 7) == 0));
      end
   endtask

   task automatic test_saturation();
      for (int n = 0; n < 260; n++) begin
         run_frame(8'hB0, 8'h01, 8'h02, 8'h03, 8'hB0 ^ 8'h01 ^ 8'h02 ^ 8'h03, 0, 0, 1'b0);
      end
      n_checks++;
      if (err_count !== 8'd255) begin
         n_fail++; $display("FAIL err_saturation got=%0d exp=255", err_count);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_good_frame();
      test_bad_checksum();
      test_duplicate();
      test_backpressure();
      test_timeout();
      test_y_range();
      test_early_drop();
      test_reset_mid_launch();
      test_random();
      test_saturation();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ball_handoff_ctrl.md
# ball_handoff_ctrl

Sequences the consumption of ball-handoff frames delivered by the I2C slave on the right board. When the slave raises `go_left`, this block snapshots the five received slave registers, validates the frame, and presents the decoded ball parameters to the game logic over a valid/ready handshake. It then acknowledges the slave on `responsing_i2c_pl` so the slave can return to its idle state. It sits between the I2C slave and the ball/game FSM, and it is the only driver of `responsing_i2c_pl`.

## Interface
- `ACK_TIMEOUT`, default 1_000_000: maximum number of cycles in ACK waiting for `go_left` to fall.
- `clk  in  1`: system clock, same domain as the I2C slave.
- `reset  in  1`: asynchronous, active-low reset.
- `slv_reg0..slv_reg4  in  8 each`: received frame bytes; stable while `go_left`=1.
- `go_left  in  1`: a frame is complete and the slave is waiting; held until acknowledged.
- `responsing_i2c_pl  out  1`: acknowledge to the slave.
- `ball_valid  out  1`: decoded ball parameters are available.
- `ball_ready  in  1`: the game logic accepts the parameters.
- `ball_y  out  9`: spawn row, 0..479.
- `ball_dir_up  out  1`: vertical direction.
- `ball_speed_x`, `ball_speed_y`  `out  3 each`: speed magnitudes.
- `remote_score  out  8`: score reported by the peer board.
- `err_count  out  8`: rejected frames, saturating.
- `dup_count  out  8`: duplicate frames, saturating.

## Operation
- Frame format:
  - reg0 = {HDR=4'hA, seq[3:0]}.
  - reg1 = y[7:0].
  - reg2 = {y[8], dir_up, speed_y[2:0], speed_x[2:0]}.
  - reg3 = remote_score.
  - reg4 = reg0^reg1^reg2^reg3.
- A frame is good when all of these hold: header nibble == 4'hA, checksum matches, and y <= 479.
- A frame is a duplicate when it is good, `seq_seen`=1, and seq == last accepted seq. `seq_seen` clears on reset.
- States are IDLE, CAPTURE, CHECK, LAUNCH, ACK.
- IDLE: when `go_left`=1, go to CAPTURE.
- CAPTURE: copy all five registers into shadow registers, then go to CHECK. All later decoding uses only the shadow copy.
- CHECK: take exactly one path.
  - Good and new: load the ball output registers, record seq, set `seq_seen`, go to LAUNCH.
  - Duplicate: increment `dup_count`, go to ACK.
  - Bad: increment `err_count`, go to ACK.
- LAUNCH: hold `ball_valid`=1. When `ball_valid` and `ball_ready` are both 1 in the same cycle, go to ACK. There is no timeout in LAUNCH; the game must eventually accept.
- ACK: hold `responsing_i2c_pl`=1.
  - When `go_left` is sampled 0, go to IDLE.
  - If the timeout counter reaches ACK_TIMEOUT-1 first, increment `err_count` and go to IDLE.
- The ACK timeout counter clears on ACK entry.
- `err_count` and `dup_count` saturate at 255.
- Ball outputs hold their last accepted values; they change only on a good, new frame.
- If `go_left` drops before ACK, the frame is still processed; ACK then exits on its first cycle.

## Timing
- Reset values: every output is 0, and the state is IDLE.
- `reset` assertion mid-frame returns to IDLE immediately and clears `seq_seen` and both counters.
- All outputs are registered; there are no combinational paths from any input to any output.
- Latency, with `go_left` sampled 1 in IDLE at cycle 0:
  - CAPTURE at cycle 1, CHECK at cycle 2.
  - Good frame: `ball_valid` rises at cycle 3. If `ball_ready`=1 in cycle 3, `responsing_i2c_pl` rises at cycle 4.
  - Bad or duplicate frame: `responsing_i2c_pl` rises at cycle 3, and the counter updates at the same edge.
- `responsing_i2c_pl` falls in the cycle after `go_left` is sampled 0. It never falls while `go_left`=1 unless the timeout fires.
- A new `go_left` is seen no earlier than the first IDLE cycle after ACK. There is at most one frame in flight.

## Structure
- Package `i2c_link_pkg` contains:
  - the state enum `handoff_state_e`;
  - `HDR_NIBBLE` = 4'hA and `Y_MAX` = 479;
  - a packed struct `ball_frame_t` with fields seq, y, dir_up, speed_y, speed_x, score.
- One sub-module, `i2c_frame_check`: purely combinational. Takes the shadow bytes; outputs `good` and the decoded `ball_frame_t`.

## Test plan
- Good frame: bytes A1, 64, 9B, 03, 5D, `ball_ready` tied to 1, then `go_left`=1 → `ball_valid` at cycle 3 with `ball_y`=356, `ball_dir_up`=0, `ball_speed_y`=3, `ball_speed_x`=3, `remote_score`=3. `responsing_i2c_pl`=1 at cycle 4 and held until `go_left`=0.
- Bad checksum: same frame with reg4=5C → no `ball_valid`, `err_count`=1, ack at cycle 3, ball outputs unchanged.
- Duplicate: send the good A1 frame twice → the second frame gives `dup_count`=1 and no `ball_valid`. A frame with seq 2 afterwards launches normally.
- Backpressure: `ball_ready`=0 for 20 cycles → `ball_valid` stays high with stable data, no ack. `ball_ready` pulse → ack on the next cycle.
- Timeout: with ACK_TIMEOUT=16, hold `go_left` high → after 16 ACK cycles, `responsing_i2c_pl` drops and `err_count` increments. Also check `y`=480 (reg1=E0, reg2 bit7=1) → rejected.
- Reset mid-LAUNCH: pull `reset` low → all outputs 0 asynchronously, state IDLE. A re-sent A1 frame is not treated as a duplicate.
